// File: rtl/wb_counter_pkg.sv
// Register map and field indices for the Wishbone up/down counter.
package wb_counter_pkg;

  // Register select taken from wb_adr_i[3:2]
  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegCount  = 2'd1;
  localparam logic [1:0] RegLoad   = 2'd2;
  localparam logic [1:0] RegStatus = 2'd3;

  localparam int unsigned CtrlEn    = 0;
  localparam int unsigned CtrlUp    = 1;
  localparam int unsigned CtrlWrap  = 2;
  localparam int unsigned CtrlLoad  = 3;
  localparam int unsigned CtrlIrqEn = 4;

  localparam int unsigned StatusTc = 0;

endpackage

// File: rtl/updown_core.sv
// Counter datapath: saturating or wrapping up/down count with preload.
module updown_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             wrap,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc_evt
);

  localparam logic [WIDTH-1:0] MaxVal = '1;
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic             at_bound;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    at_bound   = up ? (count == MaxVal) : (count == '0);
    // A step attempt at the boundary flags TC even when saturating in place
    tc_evt     = en & ~load & at_bound;
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (en) begin
      if (!at_bound) begin
        count_next = up ? count + One : count - One;
      end else if (wrap) begin
        count_next = up ? '0 : MaxVal;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/wb_updown_counter.sv
// Wishbone classic slave wrapping updown_core with CTRL/COUNT/LOAD/STATUS registers.
// Define WB_COUNTER_IRQ_EN to enable CTRL.IRQ_EN and the irq_o output.
module wb_updown_counter
  import wb_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             irq_o
);

  logic             req, wr, ctrl_wr;
  logic [1:0]       reg_sel;
  logic             ctrl_en, ctrl_up, ctrl_wrap, ctrl_irq_en;
  logic [WIDTH-1:0] load_reg;
  logic             load_strobe, tc_clr, tc_evt, tc_next;
  logic [31:0]      rd_data;
  logic             unused_bits;

  // Gating on ack keeps a held strobe from producing back-to-back acks
  assign req         = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr          = req & wb_we_i;
  assign reg_sel     = wb_adr_i[3:2];
  assign ctrl_wr     = wr & (reg_sel == RegCtrl);
  assign load_strobe = ctrl_wr & wb_dat_i[CtrlLoad];
  assign tc_clr      = wr & (reg_sel == RegStatus) & wb_dat_i[StatusTc];
  assign tc_next     = tc_evt | (tc_o & ~tc_clr);
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

  updown_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_en),
    .up       (ctrl_up),
    .wrap     (ctrl_wrap),
    .load     (load_strobe),
    .load_val (load_reg),
    .count    (count_o),
    .tc_evt   (tc_evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en   <= 1'b0;
      ctrl_up   <= 1'b0;
      ctrl_wrap <= 1'b0;
      load_reg  <= '0;
      tc_o      <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en   <= wb_dat_i[CtrlEn];
        ctrl_up   <= wb_dat_i[CtrlUp];
        ctrl_wrap <= wb_dat_i[CtrlWrap];
      end
      if (wr && reg_sel == RegLoad) begin
        load_reg <= wb_dat_i[WIDTH-1:0];
      end
      tc_o <= tc_next;
    end
  end

`ifdef WB_COUNTER_IRQ_EN
  logic irq_en_next;
  assign irq_en_next = ctrl_wr ? wb_dat_i[CtrlIrqEn] : ctrl_irq_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_irq_en <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      ctrl_irq_en <= irq_en_next;
      irq_o       <= tc_next & irq_en_next;
    end
  end
`else
  assign ctrl_irq_en = 1'b0;
  assign irq_o       = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    if (req && !wb_we_i) begin
      case (reg_sel)
        RegCtrl: begin
          rd_data[CtrlEn]    = ctrl_en;
          rd_data[CtrlUp]    = ctrl_up;
          rd_data[CtrlWrap]  = ctrl_wrap;
          rd_data[CtrlIrqEn] = ctrl_irq_en;
        end
        RegCount:  rd_data = 32'(count_o);
        RegLoad:   rd_data = 32'(load_reg);
        RegStatus: rd_data[StatusTc] = tc_o;
        default:   rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= rd_data;
    end
  end

endmodule

// File: tb/tb_wb_updown_counter.sv
// Randomized self-checking bench for wb_updown_counter (WIDTH=4) against a behavioural model.
module tb_wb_updown_counter;

  localparam int unsigned W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]    wb_adr_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic [W-1:0]  count_o;
  logic          tc_o, irq_o;

  wb_updown_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .count_o  (count_o),
    .tc_o     (tc_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_count, m_load;
  bit m_en, m_up, m_wrap, m_irq_en, m_tc, m_ack;
  logic [31:0] m_dat;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_count = 0; m_load = 0;
    m_en = 0; m_up = 0; m_wrap = 0; m_irq_en = 0; m_tc = 0; m_ack = 0;
    m_dat = '0;
  endfunction

  function automatic bit exp_irq();
`ifdef WB_COUNTER_IRQ_EN
    return m_tc && m_irq_en;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs(input string ctx);
    check_eq({ctx, ".ack"}, 32'(wb_ack_o), 32'(m_ack));
    if (m_ack) check_eq({ctx, ".dat"}, wb_dat_o, m_dat);
    check_eq({ctx, ".count"}, 32'(count_o), 32'(m_count));
    check_eq({ctx, ".tc"}, 32'(tc_o), 32'(m_tc));
    check_eq({ctx, ".irq"}, 32'(irq_o), 32'(exp_irq()));
  endtask

  // Apply one clock of bus inputs, advance the model by one edge, then compare.
  task automatic tick(input bit stb, input bit we, input logic [3:0] adr, input logic [31:0] dat);
    bit req, is_wr, strobe, evt;
    int sel, nc;
    logic [31:0] rd;
    wb_cyc_i = stb; wb_stb_i = stb; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    req = stb && !m_ack;
    is_wr = req && we;
    sel = int'(adr[3:2]);
    rd = '0;
    if (req && !we) begin
      case (sel)
        0: rd = 32'(m_en) | (32'(m_up) << 1) | (32'(m_wrap) << 2) | (32'(m_irq_en) << 4);
        1: rd = 32'(m_count);
        2: rd = 32'(m_load);
        default: rd = 32'(m_tc);
      endcase
    end
    strobe = is_wr && sel == 0 && dat[3];
    evt = 0;
    nc = m_count;
    if (strobe) nc = m_load;
    else if (m_en) begin
      if (m_up) begin
        if (m_count == MAXV) begin evt = 1; nc = m_wrap ? 0 : MAXV; end
        else nc = m_count + 1;
      end else begin
        if (m_count == 0) begin evt = 1; nc = m_wrap ? MAXV : 0; end
        else nc = m_count - 1;
      end
    end
    m_count = nc;
    if (evt) m_tc = 1;
    else if (is_wr && sel == 3 && dat[0]) m_tc = 0;
    if (is_wr && sel == 0) begin
      m_en = dat[0]; m_up = dat[1]; m_wrap = dat[2];
`ifdef WB_COUNTER_IRQ_EN
      m_irq_en = dat[4];
`endif
    end
    if (is_wr && sel == 2) m_load = int'(dat) & MAXV;
    m_ack = req;
    m_dat = rd;
    @(posedge clk);
    #1;
    check_outputs("tick");
  endtask

  task automatic bus_wr(input logic [3:0] adr, input logic [31:0] dat);
    tick(1, 1, adr, dat);
    tick(0, 0, 4'h0, 32'h0);
  endtask

  task automatic bus_rd(input logic [3:0] adr);
    tick(1, 0, adr, 32'h0);
    tick(0, 0, 4'h0, 32'h0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;
    tick(0, 0, 4'h0, 32'h0);

    for (int a = 0; a < 16; a += 4) bus_rd(4'(a));

    // Preload then strobe
    bus_wr(4'h8, 32'hD);
    bus_wr(4'h0, 32'h8);
    bus_rd(4'h0);

    // Up, saturate, run into the top
    bus_wr(4'h0, 32'h3);
    repeat (4) tick(0, 0, 4'h0, 32'h0);
    bus_wr(4'h0, 32'h13);
    repeat (2) tick(0, 0, 4'h0, 32'h0);
    bus_rd(4'hC);

    // Down, wrap from 1
    bus_wr(4'h8, 32'h1);
    bus_wr(4'h0, 32'h8);
    bus_wr(4'hC, 32'h1);
    bus_wr(4'h0, 32'h5);
    repeat (3) tick(0, 0, 4'h0, 32'h0);

    // W1C racing a saturating boundary hold, then a clean clear
    bus_wr(4'h0, 32'h1);
    repeat (16) tick(0, 0, 4'h0, 32'h0);
    bus_wr(4'hC, 32'h1);
    bus_wr(4'h0, 32'h0);
    bus_wr(4'hC, 32'h1);
    bus_rd(4'hC);

    // Held strobe: ack every second cycle
    repeat (4) tick(1, 0, 4'h4, 32'h0);
    tick(0, 0, 4'h0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] adr;
      logic [31:0] dat;
      adr = 4'($urandom_range(0, 15));
      dat = $urandom;
      case ($urandom_range(0, 4))
        0: tick(0, 0, 4'h0, 32'h0);
        1: bus_rd(adr);
        2: bus_wr(adr, (adr[3:2] == 2'd0) ? (dat & 32'h1F) : dat);
        3: bus_wr(4'h0, dat & 32'h17);
        default: begin
          tick(1, dat[0], adr, dat & 32'h17);
          tick(1, dat[0], adr, dat & 32'h17);
        end
      endcase
    end

    // Asynchronous reset while counting at 7 with a strobe pending
    bus_wr(4'h8, 32'h6);
    bus_wr(4'h0, 32'h8);
    bus_wr(4'h0, 32'h13);
    check_eq("pre_rst.count", 32'(count_o), 32'h7);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'h4;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    #2 rst = 1'b0;
    repeat (3) tick(0, 0, 4'h0, 32'h0);
    bus_rd(4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_updown_counter.md
# wb_updown_counter

Parametrised up/down counter with a Wishbone classic slave register interface, replacing the fixed 4-bit saturating counter in the SoC peripheral set. Software selects the count direction and the boundary mode (saturate or wrap), preloads a start value and reads a sticky terminal-count flag. The live count is also exported as a port for on-chip consumers.

## Interface
Parameters:
- WIDTH, 16, counter width in bits, legal 1..32

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  one clock; reset is asynchronous and active-high
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write, 0 = read
- wb_adr_i  in  4  byte address, bits [3:2] decode the register, bits [1:0] ignored
- wb_dat_i  in  32  write data; wb_sel_i not implemented, full-word writes only
- wb_dat_o  out  32  read data, registered, valid while wb_ack_o = 1
- wb_ack_o  out  1  single-cycle acknowledge
- count_o  out  WIDTH  current count, registered
- tc_o  out  1  sticky terminal-count flag (same as STATUS.TC)
- irq_o  out  1  interrupt, level (see Configuration)

## Operation
- Registers (offset: field):
  - 0x0 CTRL: [0] EN, [1] UP (1 = up, 0 = down), [2] WRAP (1 = wrap, 0 = saturate), [3] LOAD (write-1 strobe, reads 0), [4] IRQ_EN
  - 0x4 COUNT: read-only, zero-extended count; writes ignored
  - 0x8 LOAD: WIDTH-bit preload value; writes truncated to WIDTH, reads zero-extended
  - 0xC STATUS: [0] TC sticky, write 1 to clear
- Count step on each clk edge with EN = 1:
  - up, count < MAX (all ones): count + 1
  - up, count = MAX: WRAP ? 0 : hold MAX; set TC
  - down, count > 0: count − 1
  - down, count = 0: WRAP ? MAX : hold 0; set TC
  - TC is set on every boundary step attempt, including repeated holds in saturate mode.
- EN = 0: count holds; TC unaffected by counting.
- LOAD strobe: count ← LOAD register (value before the same write, since LOAD is a separate register); overrides any step in that cycle; does not set TC.
- Simultaneous events:
  - LOAD strobe beats count step.
  - TC set beats a same-cycle W1C clear.
- Unmapped/ignored accesses: always acked; read returns 0.
- Reset values: count_o 0, CTRL 0, LOAD 0, TC 0, tc_o 0, irq_o 0, wb_ack_o 0, wb_dat_o 0.
- Reset asserted mid-operation or mid-bus-cycle: all state clears immediately; a pending access is dropped (no ack) and must be reissued.

## Timing
- Bus access: cyc & stb & !ack sampled at edge N → wb_ack_o = 1 and wb_dat_o valid after edge N, for exactly one cycle.
- Write side effects are committed at edge N, visible on count_o/tc_o in the same cycle as the ack.
- Held stb produces an ack every second cycle; no back-to-back acks.
- New CTRL values govern the step at edge N+1 onward.
- count_o and COUNT reads reflect the value after the most recent edge; COUNT read data is captured at edge N.

## Configuration
- Macro WB_COUNTER_IRQ_EN:
  - Defined: irq_o = TC & CTRL.IRQ_EN, registered with the TC update; CTRL[4] read/write.
  - Undefined: irq_o tied 0; CTRL[4] reads 0 and writes are ignored.

## Structure
- Package wb_counter_pkg: register offsets (CTRL/COUNT/LOAD/STATUS), CTRL bit indices, STATUS bit indices.
- Sub-module updown_core: pure counter datapath.
  - Inputs: en, up, wrap, load, load_val
  - Outputs: count, tc_evt
- The top level holds the Wishbone decode, registers, TC sticky logic and IRQ.

## Test plan
- Reset, WIDTH=4: after rst release all outputs 0; read CTRL/COUNT/LOAD/STATUS → 0, each acked one cycle after stb.
- Write LOAD=0xD, CTRL=0x8 (LOAD strobe) → count_o = 0xD with ack; CTRL reads 0x0.
- CTRL=0x3 (EN, up, saturate) from 0xD → 0xE, 0xF, 0xF, 0xF; TC = 1 at the first hold; irq_o = 1 only with macro defined and IRQ_EN set.
- CTRL=0x5 (EN, down, wrap) from 0x1 → 0x0, 0xF, 0xE; TC set on the 0→0xF step.
- Write STATUS=1 on the same edge as a boundary step → TC stays 1; W1C with no event → TC = 0, irq_o = 0.
- Assert rst while counting at 0x7 with stb held → count_o = 0 immediately, no ack for the pending access, counting idle after release.
